uart_prog_loader: RTL and testbench

- Receives the boot program from the host over UART as a stream of bytes from the existing UART receiver.
- Assembles each group of 4 bytes into a 32-bit word, big-endian: the first byte goes to [31:24].
- Writes each word into instruction memory through a req/gnt port at consecutive word addresses starting at 0.
- Holds the core in reset until the end-of-program word arrives. Sits between the UART RX and the instruction memory, ahead of the core.

---
 rtl/uart_prog_loader.sv | 144 ++++++++++++++
 tb/tb_uart_prog_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: packs UART bytes into big-endian words, writes them to instruction
// memory over req/gnt, and holds the core in reset until the terminator word arrives.
module uart_prog_loader #(
    parameter int          ADDR_W         = 14,
    parameter logic [31:0] EOF_WORD       = 32'h0000_0FFF,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_byte_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    output logic              ready_o,
    output logic              done_o,
    output logic              core_rst_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;

    state_t          r_state;
    logic [31:0]     r_word;
    logic [1:0]      r_bidx;
    logic [ADDR_W:0] r_addr;
    logic            r_pend_v;
    logic [7:0]      r_pend_b;
    logic [TW-1:0]   r_tmo;
    logic            r_req;
    logic            r_ready;
    logic            r_done;
    logic            r_core_rst;
    logic            r_err;
    logic [1:0]      r_err_code;

    logic            w_have;
    logic [7:0]      w_byte;
    logic [31:0]     w_word;

    // The buffered byte always goes first; a fresh rx byte then takes its place.
    assign w_have = r_pend_v | rx_valid_i;
    assign w_byte = r_pend_v ? r_pend_b : rx_byte_i;
    assign w_word = {r_word[23:0], w_byte};

    assign mem_req_o    = r_req;
    assign mem_we_o     = r_req;
    assign mem_addr_o   = r_addr[ADDR_W-1:0];
    assign mem_wdata_o  = r_word;
    assign ready_o      = r_ready;
    assign done_o       = r_done;
    assign core_rst_o   = r_core_rst;
    assign word_count_o = r_addr;
    assign err_o        = r_err;
    assign err_code_o   = r_err_code;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_bidx     <= '0;
            r_addr     <= '0;
            r_pend_v   <= 1'b0;
            r_pend_b   <= '0;
            r_tmo      <= '0;
            r_req      <= 1'b0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_core_rst <= 1'b1;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else if (!en_i && (r_state == RECV || r_state == DONE)) begin
            r_state    <= IDLE;
            r_bidx     <= '0;
            r_addr     <= '0;
            r_pend_v   <= 1'b0;
            r_tmo      <= '0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_core_rst <= 1'b1;
        end else begin
            case (r_state)
                IDLE: if (en_i) r_state <= RECV;
                RECV: begin
                    r_ready  <= 1'b1;
                    r_pend_v <= r_pend_v & rx_valid_i;
                    if (rx_valid_i) r_pend_b <= rx_byte_i;
                    r_tmo <= (w_have || r_bidx == 2'd0) ? '0 : r_tmo + TW'(1);
                    if (w_have) begin
                        r_word <= w_word;
                        r_bidx <= r_bidx + 2'd1;
                        if (r_bidx == 2'd3) begin
                            r_ready <= 1'b0;
                            if (w_word == EOF_WORD) begin
                                r_state    <= DONE;
                                r_done     <= 1'b1;
                                r_core_rst <= 1'b0;
                            end else if (r_addr[ADDR_W]) begin
                                r_state    <= ERR;
                                r_err      <= 1'b1;
                                r_err_code <= 2'd2;
                            end else begin
                                r_state <= WRITE;
                                r_req   <= 1'b1;
                            end
                        end
                    end else if (r_bidx != 2'd0 && r_tmo == TMO_LAST) begin
                        r_state    <= ERR;
                        r_ready    <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= 2'd3;
                    end
                end
                WRITE: begin
                    if (rx_valid_i && r_pend_v) begin
                        r_state    <= ERR;
                        r_req      <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= 2'd1;
                    end else begin
                        if (rx_valid_i) begin
                            r_pend_v <= 1'b1;
                            r_pend_b <= rx_byte_i;
                        end
                        // A falling en_i is honoured in RECV once the handshake completes.
                        if (mem_gnt_i) begin
                            r_req   <= 1'b0;
                            r_addr  <= r_addr + (ADDR_W + 1)'(1);
                            r_state <= RECV;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: randomized bench for uart_prog_loader with a byte-stream reference model
// that derives the expected memory image, word count and final status.
module tb_uart_prog_loader;
    localparam int          AW  = 2;
    localparam int          TMO = 50;
    localparam logic [31:0] EOF = 32'h0000_0FFF;

    logic            clk = 1'b0, rst = 1'b1, en = 1'b0, rx_valid = 1'b0;
    logic [7:0]      rx_byte = 8'h00;
    logic            mem_req, mem_we, mem_gnt, ready, done, core_rst, err;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_wdata;
    logic [AW:0]     word_count;
    logic [1:0]      err_code;

    int checks = 0, errors = 0, stall = 0, req_age = 0;
    logic [AW+31:0] wr_q[$];
    logic [31:0]    exp_q[$];
    logic [7:0]     bytes[$];
    logic           exp_done;
    logic [1:0]     exp_code;

    uart_prog_loader #(.ADDR_W(AW), .EOF_WORD(EOF), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .rx_valid_i(rx_valid), .rx_byte_i(rx_byte),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_gnt_i(mem_gnt), .ready_o(ready), .done_o(done), .core_rst_o(core_rst),
        .word_count_o(word_count), .err_o(err), .err_code_o(err_code)
    );

    always #5 clk = ~clk;

    // Memory side: grant once req has waited `stall` cycles, and log every completed write.
    assign mem_gnt = mem_req && (req_age >= stall);
    always @(posedge clk) begin
        req_age <= (mem_req && !mem_gnt) ? req_age + 1 : 0;
        if (!rst && mem_req && mem_gnt) wr_q.push_back({mem_addr, mem_wdata});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; rx_valid = 1'b0; stall = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wr_q.delete();
        bytes.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!ready && n < 200) begin @(negedge clk); n++; end
        if (!ready) begin
            checks++; errors++;
            $display("FAIL send_byte: ready=%0b after %0d cycles, required 1", ready, n);
        end
        rx_valid = 1'b1; rx_byte = b; bytes.push_back(b);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        do w = $urandom; while (w == EOF);
        return w;
    endfunction

    // Reference: split the byte stream into big-endian words, stop at the terminator,
    // and refuse writes beyond the memory size.
    task automatic model();
        logic [31:0] w;
        exp_q.delete(); exp_done = 1'b0; exp_code = 2'd0;
        for (int i = 0; i + 3 < bytes.size(); i += 4) begin
            w = {bytes[i], bytes[i+1], bytes[i+2], bytes[i+3]};
            if (w == EOF) begin exp_done = 1'b1; break; end
            if (exp_q.size() == (1 << AW)) begin exp_code = 2'd2; break; end
            exp_q.push_back(w);
        end
    endtask

    task automatic wait_end(output bit ok);
        int n = 0;
        while (!(done || err) && n < 500) begin @(negedge clk); n++; end
        ok = done || err;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({mem_req, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_req: got %b, required 00", {mem_req, mem_we}); end
        checks++; if ({mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL reset_mem: addr=%0h data=%h, required 0", mem_addr, mem_wdata); end
        checks++; if ({ready, done, core_rst} !== 3'b001) begin errors++; $display("FAIL reset_status: ready/done/core_rst=%b, required 001", {ready, done, core_rst}); end
        checks++; if (word_count !== '0) begin errors++; $display("FAIL reset_count: got %0d, required 0", word_count); end
        checks++; if ({err, err_code} !== 3'b000) begin errors++; $display("FAIL reset_err: got %b, required 000", {err, err_code}); end
    endtask

    task automatic test_normal();
        logic [7:0] seq[12] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h0F, 8'hFF};
        bit ok;
        do_reset();
        en = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_first_recv: got %b, required 0", ready); end
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ready_rise: got %b, required 1", ready); end
        foreach (seq[i]) send_byte(seq[i]);
        wait_end(ok);
        checks++; if (!ok) begin errors++; $display("FAIL normal_end: done/err never rose"); end
        checks++; if (wr_q.size() !== 2) begin errors++; $display("FAIL normal_handshakes: got %0d, required 2", wr_q.size()); end
        checks++; if (wr_q.size() > 0 && wr_q[0] !== {2'd0, 32'hDEADBEEF}) begin errors++; $display("FAIL normal_mem0: got %h, required 0deadbeef", wr_q[0]); end
        checks++; if (wr_q.size() > 1 && wr_q[1] !== {2'd1, 32'h00000013}) begin errors++; $display("FAIL normal_mem1: got %h, required 100000013", wr_q[1]); end
        checks++; if ({word_count, done, core_rst, ready, err} !== {3'd2, 4'b1000}) begin errors++; $display("FAIL normal_status: count=%0d done=%b core_rst=%b ready=%b err=%b, required 2 1 0 0 0", word_count, done, core_rst, ready, err); end
    endtask

    task automatic test_random();
        bit ok;
        int n;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            stall = $urandom_range(0, 3);
            en = 1'b1;
            n = $urandom_range(0, 3);
            repeat (n) send_word(rand_word());
            send_word(EOF);
            model();
            wait_end(ok);
            checks++; if (!ok) begin errors++; $display("FAIL random_end[%0d]: done/err never rose", it); end
            checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_writes[%0d]: got %0d, required %0d", it, wr_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < wr_q.size()) begin
                checks++; if (wr_q[i] !== {AW'(i), exp_q[i]}) begin errors++; $display("FAIL random_mem[%0d][%0d]: got %h, required %h", it, i, wr_q[i], {AW'(i), exp_q[i]}); end
            end
            checks++; if ({done, err_code, word_count} !== {exp_done, exp_code, (AW+1)'(exp_q.size())}) begin errors++; $display("FAIL random_status[%0d]: done=%b code=%0d count=%0d, required %b %0d %0d", it, done, err_code, word_count, exp_done, exp_code, exp_q.size()); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] w0, w1;
        bit ok;
        do_reset();
        stall = 20;
        en = 1'b1;
        w0 = rand_word(); w1 = rand_word();
        w1[31:24] = 8'h11;
        send_word(w0);
        for (int i = 0; i < 20; i++) begin
            checks++; if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 2'd0, w0}) begin errors++; $display("FAIL stall_stable[%0d]: req=%b addr=%0d data=%h, required 1 0 %h", i, mem_req, mem_addr, mem_wdata, w0); end
            rx_valid = (i == 5); rx_byte = 8'h11;
            if (i == 5) bytes.push_back(8'h11);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        for (int i = 2; i >= 0; i--) send_byte(w1[i*8 +: 8]);
        send_word(EOF);
        model();
        wait_end(ok);
        checks++; if (wr_q.size() !== 2) begin errors++; $display("FAIL stall_writes: got %0d, required 2", wr_q.size()); end
        checks++; if (wr_q.size() > 1 && wr_q[1] !== {2'd1, w1}) begin errors++; $display("FAIL stall_word1: got %h, required %h", wr_q[1], {2'd1, w1}); end
        checks++; if ({err, done} !== 2'b01) begin errors++; $display("FAIL stall_status: err=%b done=%b, required 0 1", err, done); end
    endtask

    task automatic test_overrun();
        do_reset();
        stall = 1 << 30;
        en = 1'b1;
        send_word(rand_word());
        rx_valid = 1'b1; rx_byte = 8'h55;
        @(negedge clk);
        rx_byte = 8'h66;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        checks++; if ({err, err_code, ready, core_rst} !== {1'b1, 2'd1, 1'b0, 1'b1}) begin errors++; $display("FAIL overrun_status: err=%b code=%0d ready=%b core_rst=%b, required 1 1 0 1", err, err_code, ready, core_rst); end
        checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL overrun_writes: got %0d, required 0", wr_q.size()); end
        en = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({err, err_code} !== {1'b1, 2'd1}) begin errors++; $display("FAIL overrun_sticky: err=%b code=%0d, required 1 1", err, err_code); end
    endtask

    task automatic test_rst_mid_write();
        do_reset();
        stall = 1 << 30;
        en = 1'b1;
        send_word(rand_word());
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstw_req_before: got %b, required 1", mem_req); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({mem_req, core_rst} !== 2'b01) begin errors++; $display("FAIL rstw_req_after: req=%b core_rst=%b, required 0 1", mem_req, core_rst); end
        rst = 1'b0;
        stall = 0;
    endtask

    task automatic test_timeout();
        do_reset();
        en = 1'b1;
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (TMO - 2) @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_early: err=%b after %0d idle cycles, required 0", err, TMO - 2); end
        repeat (4) @(negedge clk);
        checks++; if ({err, err_code, core_rst} !== {1'b1, 2'd3, 1'b1}) begin errors++; $display("FAIL timeout_status: err=%b code=%0d core_rst=%b, required 1 3 1", err, err_code, core_rst); end
        checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL timeout_writes: got %0d, required 0", wr_q.size()); end
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        en = 1'b1;
        repeat (5) send_word(rand_word());
        model();
        wait_end(ok);
        checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL overflow_writes: got %0d, required %0d", wr_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            checks++; if (wr_q[i] !== {AW'(i), exp_q[i]}) begin errors++; $display("FAIL overflow_mem[%0d]: got %h, required %h", i, wr_q[i], {AW'(i), exp_q[i]}); end
        end
        checks++; if ({err, err_code, word_count, done} !== {1'b1, exp_code, 3'd4, 1'b0}) begin errors++; $display("FAIL overflow_status: err=%b code=%0d count=%0d done=%b, required 1 %0d 4 0", err, err_code, word_count, done, exp_code); end
    endtask

    task automatic test_en_drop();
        logic [31:0] w;
        bit ok;
        do_reset();
        en = 1'b1;
        w = rand_word();
        for (int i = 3; i >= 1; i--) send_byte(w[i*8 +: 8]);
        en = 1'b0; rx_valid = 1'b1; rx_byte = w[7:0];
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({mem_req, ready, core_rst, word_count} !== {3'b001, 3'd0}) begin errors++; $display("FAIL endrop_idle: req=%b ready=%b core_rst=%b count=%0d, required 0 0 1 0", mem_req, ready, core_rst, word_count); end
        checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL endrop_nowrite: got %0d, required 0", wr_q.size()); end
        bytes.delete();
        en = 1'b1;
        send_word(rand_word());
        send_word(EOF);
        model();
        wait_end(ok);
        checks++; if (wr_q.size() !== 1 || wr_q[0] !== {2'd0, exp_q[0]}) begin errors++; $display("FAIL endrop_word: n=%0d first=%h, required 1 %h", wr_q.size(), wr_q.size() ? wr_q[0] : '0, {2'd0, exp_q[0]}); end
        checks++; if ({done, core_rst, word_count} !== {2'b10, 3'd1}) begin errors++; $display("FAIL endrop_done: done=%b core_rst=%b count=%0d, required 1 0 1", done, core_rst, word_count); end
        en = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({done, core_rst, word_count} !== {2'b01, 3'd0}) begin errors++; $display("FAIL endrop_leave_done: done=%b core_rst=%b count=%0d, required 0 1 0", done, core_rst, word_count); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_random();
        test_stall();
        test_overrun();
        test_rst_mid_write();
        test_timeout();
        test_overflow();
        test_en_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
